sram_ctrl: RTL and testbench
============================

# sram_ctrl

Sequencer for the single-port SRAM macro. It accepts one read or write request at a time over a valid/ready handshake and decodes the address into a one-hot row select and a one-hot word select; the word select drives `column_mux.col_select`. It then steps the array through precharge, wordline access and sense or write phases. On reads it captures the 4-bit word coming back from `column_mux.data_out` and returns it with a one-cycle response pulse.

## Interface

Parameters:
- `WORD_SIZE`, 4: bits per word; must match `column_mux`.
- `NUM_WORDS`, 16: words per row, a power of 2; must match `column_mux`.
- `NUM_ROWS`, 16: wordlines, a power of 2.
- `PRE_CYCLES`, 1: precharge phase length; must be ≥ 1.
- `ACC_CYCLES`, 2: wordline-on phase length; must be ≥ 1.
- `ADDR_W`, derived: log2(NUM_ROWS) + log2(NUM_WORDS), which is 8 with the defaults.

Ports:
- `clk`, in, 1: the single clock; everything is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: controller can accept a request.
- `req_we`, in, 1: 1 = write, 0 = read.
- `req_addr`, in, ADDR_W: upper log2(NUM_ROWS) bits are the row; lower log2(NUM_WORDS) bits are the word.
- `req_wdata`, in, WORD_SIZE: write data.
- `precharge_en`, out, 1: bitline precharge.
- `row_sel`, out, NUM_ROWS: one-hot wordline select.
- `col_select`, out, NUM_WORDS: one-hot word select, driven to `column_mux`.
- `wl_en`, out, 1: wordline enable.
- `sense_en`, out, 1: sense-amp enable.
- `wr_en`, out, 1: write driver enable.
- `wr_data`, out, WORD_SIZE: write driver data.
- `mux_data`, in, WORD_SIZE: from `column_mux.data_out`.
- `rsp_valid`, out, 1: one-cycle completion pulse.
- `rsp_rdata`, out, WORD_SIZE: read result.

## Operation

- All outputs are registered. On reset every output is 0 and the FSM goes to IDLE, except `req_ready`, which is 1 in IDLE after reset.
- FSM states are IDLE → PRE → ACC → DONE → IDLE.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid & req_ready`, latch `req_we`, the row index, the word index and `req_wdata`, then go to PRE.
  - `req_ready` is 1 only in IDLE.
  - Requests presented while busy are neither accepted nor queued; the requester holds them.
- **PRE**
  - `precharge_en` = 1 for PRE_CYCLES cycles.
  - All selects and enables are 0.
  - A down-counter tracks the phase length; go to ACC when it expires.
- **ACC**, lasting ACC_CYCLES cycles:
  - `precharge_en` = 0, `wl_en` = 1.
  - `row_sel` = 1 << row, `col_select` = 1 << word.
  - Read:
    - `sense_en` = 1 on the last ACC cycle only.
    - `mux_data` is captured into `rsp_rdata` at the clock edge that ends that cycle.
  - Write:
    - `wr_en` = 1 and `wr_data` = latched wdata on every ACC cycle.
    - `sense_en` stays 0.
- **DONE**
  - `rsp_valid` = 1 for exactly one cycle; all selects and enables are 0.
  - Go to IDLE.
- Writes also pulse `rsp_valid` as an acknowledgement; `rsp_rdata` is unchanged by a write.
- `rsp_rdata` holds its value until the next read completes.
- Outside ACC, `row_sel`, `col_select` and `wl_en` are 0, so no two wordlines are ever active.
- `wr_data` is 0 whenever `wr_en` is 0.
- `precharge_en` and `wl_en` are never 1 in the same cycle.
- Reset asserted mid-operation aborts the access with no `rsp_valid`. After `rst_n` rises, the first accept is possible on the first clock edge.

## Timing

- Call the accept edge E0.
- PRE occupies cycles E0 to E0+PRE_CYCLES.
- ACC occupies the next ACC_CYCLES cycles.
- `rsp_valid` is high for the cycle starting at edge E0+PRE_CYCLES+ACC_CYCLES. With the defaults this is E0+3.
- `rsp_rdata` is valid in that same cycle.
- `req_ready` returns to 1 one cycle after `rsp_valid`. Back-to-back throughput is one access per PRE_CYCLES+ACC_CYCLES+2 cycles, which is 5 with the defaults.
- `mux_data` must be stable at the final ACC edge. `column_mux` is combinational, so it sees `col_select` one full cycle before the capture edge.

## Test plan

- **Reset values:** `rst_n` = 0 mid-simulation → every output is 0 except `req_ready` = 1. `req_valid` held during reset is not accepted.
- **Single read:** read at `req_addr` = 0x5A with the bench driving `mux_data` = 0xC in the last ACC cycle →
  - `row_sel` = 0x0020 and `col_select` = 0x0400 for exactly 2 cycles;
  - `sense_en` is high only in the second of those cycles;
  - `rsp_valid` pulses at E0+3 with `rsp_rdata` = 0xC.
- **Single write:** write at `req_addr` = 0xF0, `req_wdata` = 0x9 → `wr_en` = 1 and `wr_data` = 0x9 for 2 cycles with `row_sel` = 0x8000 and `col_select` = 0x0001. `rsp_valid` pulses and `rsp_rdata` keeps its prior value.
- **Busy backpressure:** `req_valid` held high continuously with 3 queued reads → accepts happen exactly 5 cycles apart, and `req_ready` is 0 from the cycle after each accept until after the DONE cycle.
- **Abort:** drop `rst_n` during ACC of a read → all outputs are 0 immediately (asynchronously), no `rsp_valid` is produced, and a new read is accepted after release.
- **Invariant sweep:** 200 random requests with PRE_CYCLES = 2 and ACC_CYCLES = 3 →
  - `row_sel` and `col_select` are each one-hot or zero;
  - `precharge_en & wl_en` is never 1;
  - latency is 5 cycles;
  - read data matches a scoreboard.

Source files
------------

// File: rtl/sram_ctrl.sv
// Single-port SRAM sequencer: one request at a time, IDLE -> PRE -> ACC -> DONE.
// Response PRE_CYCLES+ACC_CYCLES cycles after accept; req_ready is low while busy (requests are held, not queued).
module sram_ctrl #(
  parameter int WORD_SIZE  = 4,
  parameter int NUM_WORDS  = 16,
  parameter int NUM_ROWS   = 16,
  parameter int PRE_CYCLES = 1,
  parameter int ACC_CYCLES = 2,
  localparam int ROW_W     = $clog2(NUM_ROWS),
  localparam int WRD_W     = $clog2(NUM_WORDS),
  localparam int ADDR_W    = ROW_W + WRD_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 precharge_en,
  output logic [NUM_ROWS-1:0]  row_sel,
  output logic [NUM_WORDS-1:0] col_select,
  output logic                 wl_en,
  output logic                 sense_en,
  output logic                 wr_en,
  output logic [WORD_SIZE-1:0] wr_data,
  input  logic [WORD_SIZE-1:0] mux_data,
  output logic                 rsp_valid,
  output logic [WORD_SIZE-1:0] rsp_rdata
);

  localparam int MAX_CYC = (PRE_CYCLES > ACC_CYCLES) ? PRE_CYCLES : ACC_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACC_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_ACC, S_DONE} state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_we;
  logic [ROW_W-1:0]     r_row;
  logic [WRD_W-1:0]     r_word;
  logic [WORD_SIZE-1:0] r_wdata;

  logic                 r_req_ready;
  logic                 r_precharge_en;
  logic [NUM_ROWS-1:0]  r_row_sel;
  logic [NUM_WORDS-1:0] r_col_select;
  logic                 r_wl_en;
  logic                 r_sense_en;
  logic                 r_wr_en;
  logic [WORD_SIZE-1:0] r_wr_data;
  logic                 r_rsp_valid;
  logic [WORD_SIZE-1:0] r_rsp_rdata;

  state_t               w_nxt_state;
  logic [CNT_W-1:0]     w_nxt_cnt;
  logic                 w_accept;
  logic                 w_capture;
  logic [NUM_ROWS-1:0]  w_row_oh;
  logic [NUM_WORDS-1:0] w_word_oh;

  logic                 w_nxt_ready;
  logic                 w_nxt_pre;
  logic [NUM_ROWS-1:0]  w_nxt_row_sel;
  logic [NUM_WORDS-1:0] w_nxt_col_sel;
  logic                 w_nxt_wl;
  logic                 w_nxt_sense;
  logic                 w_nxt_wr_en;
  logic [WORD_SIZE-1:0] w_nxt_wr_data;
  logic                 w_nxt_rsp_vld;

  assign w_accept  = req_valid & r_req_ready;
  assign w_capture = (r_state == S_ACC) && (r_cnt == '0) && !r_we;
  assign w_row_oh  = NUM_ROWS'(1) << r_row;
  assign w_word_oh = NUM_WORDS'(1) << r_word;

  // Outputs are computed from the next state so every output leaves a flop.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_cnt     = r_cnt;
    w_nxt_ready   = 1'b0;
    w_nxt_pre     = 1'b0;
    w_nxt_row_sel = '0;
    w_nxt_col_sel = '0;
    w_nxt_wl      = 1'b0;
    w_nxt_sense   = 1'b0;
    w_nxt_wr_en   = 1'b0;
    w_nxt_wr_data = '0;
    w_nxt_rsp_vld = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_nxt_state = S_PRE;
          w_nxt_cnt   = PRE_LOAD;
        end
      end
      S_PRE: begin
        if (r_cnt == '0) begin
          w_nxt_state = S_ACC;
          w_nxt_cnt   = ACC_LOAD;
        end else begin
          w_nxt_cnt = r_cnt - 1'b1;
        end
      end
      S_ACC: begin
        if (r_cnt == '0) begin
          w_nxt_state = S_DONE;
        end else begin
          w_nxt_cnt = r_cnt - 1'b1;
        end
      end
      S_DONE:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase

    case (w_nxt_state)
      S_IDLE: w_nxt_ready = 1'b1;
      S_PRE:  w_nxt_pre   = 1'b1;
      S_ACC: begin
        w_nxt_wl      = 1'b1;
        w_nxt_row_sel = w_row_oh;
        w_nxt_col_sel = w_word_oh;
        w_nxt_wr_en   = r_we;
        w_nxt_wr_data = r_we ? r_wdata : '0;
        // Sense only on the final wordline cycle so bitlines have fully developed.
        w_nxt_sense   = !r_we && (w_nxt_cnt == '0);
      end
      S_DONE:  w_nxt_rsp_vld = 1'b1;
      default: w_nxt_ready   = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_we           <= 1'b0;
      r_row          <= '0;
      r_word         <= '0;
      r_wdata        <= '0;
      r_req_ready    <= 1'b1;
      r_precharge_en <= 1'b0;
      r_row_sel      <= '0;
      r_col_select   <= '0;
      r_wl_en        <= 1'b0;
      r_sense_en     <= 1'b0;
      r_wr_en        <= 1'b0;
      r_wr_data      <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_rdata    <= '0;
    end else begin
      r_state        <= w_nxt_state;
      r_cnt          <= w_nxt_cnt;
      r_req_ready    <= w_nxt_ready;
      r_precharge_en <= w_nxt_pre;
      r_row_sel      <= w_nxt_row_sel;
      r_col_select   <= w_nxt_col_sel;
      r_wl_en        <= w_nxt_wl;
      r_sense_en     <= w_nxt_sense;
      r_wr_en        <= w_nxt_wr_en;
      r_wr_data      <= w_nxt_wr_data;
      r_rsp_valid    <= w_nxt_rsp_vld;
      if (w_accept) begin
        r_we    <= req_we;
        r_row   <= req_addr[ADDR_W-1:WRD_W];
        r_word  <= req_addr[WRD_W-1:0];
        r_wdata <= req_wdata;
      end
      if (w_capture) begin
        r_rsp_rdata <= mux_data;
      end
    end
  end

  assign req_ready    = r_req_ready;
  assign precharge_en = r_precharge_en;
  assign row_sel      = r_row_sel;
  assign col_select   = r_col_select;
  assign wl_en        = r_wl_en;
  assign sense_en     = r_sense_en;
  assign wr_en        = r_wr_en;
  assign wr_data      = r_wr_data;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: default-timing instance for directed tests, PRE=2/ACC=3 instance for a random sweep.
module tb_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        req_valid, req_we, req_ready, precharge_en, wl_en, sense_en, wr_en, rsp_valid;
  logic [7:0]  req_addr;
  logic [3:0]  req_wdata, mux_data, wr_data, rsp_rdata;
  logic [15:0] row_sel, col_select;

  logic        req_valid2, req_we2, req_ready2, precharge_en2, wl_en2, sense_en2, wr_en2, rsp_valid2;
  logic [7:0]  req_addr2;
  logic [3:0]  req_wdata2, mux_data2, wr_data2, rsp_rdata2;
  logic [15:0] row_sel2, col_select2;

  sram_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .precharge_en(precharge_en), .row_sel(row_sel),
    .col_select(col_select), .wl_en(wl_en), .sense_en(sense_en), .wr_en(wr_en), .wr_data(wr_data),
    .mux_data(mux_data), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
  );

  sram_ctrl #(.PRE_CYCLES(2), .ACC_CYCLES(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
    .req_addr(req_addr2), .req_wdata(req_wdata2), .precharge_en(precharge_en2), .row_sel(row_sel2),
    .col_select(col_select2), .wl_en(wl_en2), .sense_en(sense_en2), .wr_en(wr_en2), .wr_data(wr_data2),
    .mux_data(mux_data2), .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboards of expected rsp_rdata, one per instance.
  logic [3:0] q1[$];
  logic [3:0] q2[$];
  logic [3:0] last1 = 4'h0;
  logic [3:0] last2 = 4'h0;

  // Cell array behind u_dut2: unwritten cells read a per-address pattern.
  bit   [3:0] arr2  [256];
  bit         arr_w2[256];
  logic [3:0] refm  [256];
  bit         refw  [256];
  logic [3:0] junk2 = 4'h0;
  logic [7:0] w_idx2;

  function automatic logic [3:0] oh2idx(input logic [15:0] v);
    logic [3:0] r = 4'h0;
    for (int i = 0; i < 16; i++) if (v[i]) r = 4'(i);
    return r;
  endfunction

  function automatic logic [3:0] seed(input logic [7:0] a);
    return a[7:4] ^ a[3:0] ^ 4'h5;
  endfunction

  assign w_idx2    = {oh2idx(row_sel2), oh2idx(col_select2)};
  assign mux_data2 = !sense_en2 ? junk2 : (arr_w2[w_idx2] ? arr2[w_idx2] : seed(w_idx2));

  always @(negedge clk) begin
    junk2 <= 4'($urandom);
    if (wr_en2) begin
      arr2[w_idx2]   <= wr_data2;
      arr_w2[w_idx2] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    check("inv_row1_onehot", 32'($onehot0(row_sel)), 32'd1);
    check("inv_col1_onehot", 32'($onehot0(col_select)), 32'd1);
    check("inv_pre_wl1", 32'(precharge_en & wl_en), 32'd0);
    check("inv_row2_onehot", 32'($onehot0(row_sel2)), 32'd1);
    check("inv_col2_onehot", 32'($onehot0(col_select2)), 32'd1);
    check("inv_pre_wl2", 32'(precharge_en2 & wl_en2), 32'd0);
    if (!wr_en)  check("inv_wrdata1_zero", 32'(wr_data), 32'd0);
    if (!wr_en2) check("inv_wrdata2_zero", 32'(wr_data2), 32'd0);
    if (rst_n && rsp_valid) begin
      check("rsp1_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) check("rsp1_rdata", 32'(rsp_rdata), 32'(q1.pop_front()));
    end
    if (rst_n && rsp_valid2) begin
      check("rsp2_expected", 32'(q2.size() != 0), 32'd1);
      if (q2.size() != 0) check("rsp2_rdata", 32'(rsp_rdata2), 32'(q2.pop_front()));
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_pre"}, 32'(precharge_en), 32'd0);
    check({tag, "_row"}, 32'(row_sel), 32'd0);
    check({tag, "_col"}, 32'(col_select), 32'd0);
    check({tag, "_wl"}, 32'(wl_en), 32'd0);
    check({tag, "_sense"}, 32'(sense_en), 32'd0);
    check({tag, "_wren"}, 32'(wr_en), 32'd0);
    check({tag, "_wrdata"}, 32'(wr_data), 32'd0);
    check({tag, "_rspv"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rdata"}, 32'(rsp_rdata), 32'd0);
  endtask

  // Reset with req_valid held: nothing may be accepted across the reset edges.
  task automatic reset_with_valid(input string tag);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h11;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    repeat (2) @(negedge clk);
    check({tag, "_held_pre"}, 32'(precharge_en), 32'd0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    q1.delete(); q2.delete();
    last1 = 4'h0; last2 = 4'h0;
    @(negedge clk);
    check({tag, "_post_pre"}, 32'(precharge_en), 32'd0);
    check({tag, "_post_ready"}, 32'(req_ready), 32'd1);
  endtask

  // One access on u_dut (PRE=1, ACC=2); called at a negedge with the controller idle.
  task automatic do_req1(input logic we, input logic [7:0] addr, input logic [3:0] wd, input logic [3:0] mv);
    logic [15:0] er, ec;
    er = 16'd1 << addr[7:4];
    ec = 16'd1 << addr[3:0];
    check("d1_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    if (!we) last1 = mv;
    q1.push_back(last1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      mux_data = (k == 2) ? mv : ~mv;
      check("d1_pre", 32'(precharge_en), 32'(k == 0));
      check("d1_wl", 32'(wl_en), 32'(k == 1 || k == 2));
      check("d1_row", 32'(row_sel), (k == 1 || k == 2) ? 32'(er) : 32'd0);
      check("d1_col", 32'(col_select), (k == 1 || k == 2) ? 32'(ec) : 32'd0);
      check("d1_sense", 32'(sense_en), 32'(!we && k == 2));
      check("d1_wren", 32'(wr_en), 32'(we && (k == 1 || k == 2)));
      check("d1_wrdata", 32'(wr_data), (we && (k == 1 || k == 2)) ? 32'(wd) : 32'd0);
      check("d1_rspv", 32'(rsp_valid), 32'(k == 3));
      check("d1_ready", 32'(req_ready), 32'(k == 4));
      if (k < 4) @(negedge clk);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int          acc_at[3];
  int          n_acc, cyc, n, k, a;
  logic        we;
  logic [3:0]  wd;
  logic [15:0] er, ec;

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 4'h0; mux_data = 4'h0;
    req_valid2 = 1'b0; req_we2 = 1'b0; req_addr2 = 8'h00; req_wdata2 = 4'h0;
    for (int i = 0; i < 256; i++) begin refm[i] = 4'h0; refw[i] = 1'b0; end
    @(negedge clk);
    reset_with_valid("rst0");

    // Single read then single write; the write must not disturb rsp_rdata.
    do_req1(1'b0, 8'h5A, 4'h0, 4'hC);
    do_req1(1'b1, 8'hF0, 4'h9, 4'h3);
    check("wr_keeps_rdata", 32'(rsp_rdata), 32'hC);

    reset_with_valid("rst_mid");

    // Busy backpressure: valid held across three reads.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h27; mux_data = 4'hA;
    n_acc = 0; cyc = 0;
    while (n_acc < 3 && cyc < 40) begin
      if (req_ready) begin
        acc_at[n_acc] = cyc;
        n_acc++;
        last1 = 4'hA;
        q1.push_back(4'hA);
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    check("busy_accepts", 32'(n_acc), 32'd3);
    check("busy_gap01", 32'(acc_at[1] - acc_at[0]), 32'd5);
    check("busy_gap12", 32'(acc_at[2] - acc_at[1]), 32'd5);
    check("busy_ready_after_accept", 32'(req_ready), 32'd0);
    repeat (4) @(negedge clk);
    check("busy_ready_back", 32'(req_ready), 32'd1);
    check("busy_q_drained", 32'(q1.size()), 32'd0);

    // Abort a read during ACC.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h33;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_in_acc", 32'(wl_en), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    last1 = 4'h0;
    for (int i = 0; i < 4; i++) begin
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    do_req1(1'b0, 8'h3C, 4'h0, 4'h6);

    // Random sweep on the PRE=2/ACC=3 instance.
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = int'($urandom_range(0, 255));
      wd = 4'($urandom);
      n = 0;
      while (!req_ready2 && n < 20) begin @(negedge clk); n++; end
      check("sw_ready", 32'(req_ready2), 32'd1);
      req_valid2 = 1'b1; req_we2 = we; req_addr2 = 8'(a); req_wdata2 = wd;
      if (we) begin
        refm[a] = wd; refw[a] = 1'b1;
      end else begin
        last2 = refw[a] ? refm[a] : seed(8'(a));
      end
      q2.push_back(last2);
      er = 16'd1 << a[7:4];
      ec = 16'd1 << a[3:0];
      @(posedge clk);
      @(negedge clk);
      req_valid2 = 1'b0;
      k = 0;
      while (!rsp_valid2 && k < 20) begin
        check("sw_pre", 32'(precharge_en2), 32'(k < 2));
        check("sw_wl", 32'(wl_en2), 32'(k >= 2));
        check("sw_sense", 32'(sense_en2), 32'(!we && k == 4));
        check("sw_wren", 32'(wr_en2), 32'(we && k >= 2));
        if (wl_en2) begin
          check("sw_row", 32'(row_sel2), 32'(er));
          check("sw_col", 32'(col_select2), 32'(ec));
        end
        @(negedge clk);
        k++;
      end
      check("sw_latency", 32'(k), 32'd5);
    end
    repeat (2) @(negedge clk);
    check("q1_empty", 32'(q1.size()), 32'd0);
    check("q2_empty", 32'(q2.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
